// File: rtl/riscv_defines.sv
// Core-wide widths and encodings shared by the execute-stage units.
package riscv_defines;

  localparam int unsigned WORD_WIDTH    = 32;
  localparam int unsigned MDU_CNT_WIDTH = $clog2(WORD_WIDTH);

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

endpackage

// File: rtl/mdu_seq.sv
// Iterative M-extension unit: shift-add multiplier and restoring divider sharing
// one 2*WORD_WIDTH accumulator; stalls EX until the result is ready.
module mdu_seq
  import riscv_defines::*;
(
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [2:0]            operator_i,
  input  logic [WORD_WIDTH-1:0] operand_a_i,
  input  logic [WORD_WIDTH-1:0] operand_b_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic [WORD_WIDTH-1:0] result_o,
  output logic                  result_valid_o,
  output logic                  busy_o
);

  localparam int unsigned W  = WORD_WIDTH;
  localparam int unsigned W2 = 2 * WORD_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e                   state_q, state_d;
  logic [MDU_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [W2-1:0]            acc_q, acc_d;
  logic [W-1:0]             opd_q, opd_d;
  mdu_op_e                  op_q, op_d;
  logic                     neg_quo_q, neg_quo_d;
  logic                     neg_rem_q, neg_rem_d;
  logic [W-1:0]             result_q, result_d;
  logic                     valid_q, valid_d;

  logic          a_signed, b_signed, sa, sb;
  logic [W-1:0]  mag_a, mag_b;
  logic [W:0]    mul_sum, div_shift, div_rem;
  logic          div_ge;
  logic [W2-1:0] acc_step;

  function automatic logic [W-1:0] fix_w(input logic [W-1:0] v, input logic neg);
    return neg ? W'(~v + W'(1)) : v;
  endfunction

  function automatic logic [W2-1:0] fix_w2(input logic [W2-1:0] v, input logic neg);
    return neg ? W2'(~v + W2'(1)) : v;
  endfunction

  // Picks the architectural result out of the final accumulator and applies the sign.
  function automatic logic [W-1:0] final_result(input mdu_op_e op, input logic [W2-1:0] acc,
                                                input logic nq, input logic nr);
    logic [W2-1:0] prod;
    prod = fix_w2(acc, nq);
    case (op)
      MDU_MUL:                        return prod[W-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: return prod[W2-1:W];
      MDU_DIV, MDU_DIVU:              return fix_w(acc[W-1:0], nq);
      default:                        return fix_w(acc[W2-1:W], nr);
    endcase
  endfunction

  always_comb begin
    a_signed = (operator_i != 3'b011) && (operator_i != 3'b101) && (operator_i != 3'b111);
    b_signed = a_signed && (operator_i != 3'b010);
    sa       = a_signed && operand_a_i[W-1];
    sb       = b_signed && operand_b_i[W-1];
    mag_a    = fix_w(operand_a_i, sa);
    mag_b    = fix_w(operand_b_i, sb);
  end

  // Multiply: acc = {partial hi, multiplier lo}; add multiplicand on lsb then shift right.
  // Divide:   acc = {remainder, dividend/quotient}; shift left, subtract if it fits.
  always_comb begin
    mul_sum   = {1'b0, acc_q[W2-1:W]} + (acc_q[0] ? {1'b0, opd_q} : (W+1)'(0));
    div_shift = {acc_q[W2-1:W], acc_q[W-1]};
    div_ge    = div_shift >= {1'b0, opd_q};
    div_rem   = div_ge ? (div_shift - {1'b0, opd_q}) : div_shift;
    if (state_q == S_MUL) acc_step = {mul_sum, acc_q[W-1:1]};
    else                  acc_step = {div_rem[W-1:0], acc_q[W-2:0], div_ge};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opd_d     = opd_q;
    op_d      = op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    valid_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d      = mdu_op_e'(operator_i);
          neg_quo_d = sa ^ sb;
          neg_rem_d = sa;
          cnt_d     = '0;
          if (!operator_i[2]) begin
            acc_d   = {W'(0), mag_b};
            opd_d   = mag_a;
            state_d = S_MUL;
          end else if (operand_b_i != '0) begin
            acc_d   = {W'(0), mag_a};
            opd_d   = mag_b;
            state_d = S_DIV;
          end else begin
            // Divide by zero: all-ones quotient, remainder is the raw dividend.
            result_d = operator_i[1] ? operand_a_i : '1;
            valid_d  = 1'b1;
            state_d  = S_DONE;
          end
        end
      end
      S_MUL, S_DIV: begin
        acc_d = acc_step;
        cnt_d = cnt_q + MDU_CNT_WIDTH'(1);
        if (cnt_q == MDU_CNT_WIDTH'(W - 1)) begin
          result_d = final_result(op_q, acc_step, neg_quo_q, neg_rem_q);
          valid_d  = 1'b1;
          cnt_d    = '0;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (flush_i) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      result_d = result_q;
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opd_q     <= '0;
      op_q      <= MDU_MUL;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opd_q     <= opd_d;
      op_q      <= op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
    end
  end

  assign stall_o        = !rst_i && !flush_i &&
                          (((state_q == S_IDLE) && start_i) || (state_q == S_MUL) || (state_q == S_DIV));
  assign result_o       = result_q;
  assign result_valid_o = valid_q;
  assign busy_o         = (state_q != S_IDLE);

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
Multi-cycle sequencer for the M-extension in the execute stage. It replaces the single-cycle combinational MDU with an iterative shift-add multiplier and a restoring divider. It stalls the pipeline while an operation is in flight and returns the 32-bit result on the cycle the EX stage may retire. It sits beside the ALU inside the EX stage and consumes the same operand_a/operand_b and alu_op_ctrl[2:0].

Parameters:
WORD_WIDTH, 32, operand/result width (taken from riscv_defines; not overridden per instance)

Ports:
clk  in  1  core clock; all state updates on rising edge
rst_i  in  1  synchronous, active-high reset
start_i  in  1  EX stage holds an M-type instruction (alu_mdu_mux asserted and instruction valid)
operator_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
operand_a_i  in  WORD_WIDTH  rs1 value
operand_b_i  in  WORD_WIDTH  rs2 value
flush_i  in  1  EX instruction killed (branch/jump redirect, trap)
stall_o  out  1  hold IF/ID/EX; combinational
result_o  out  WORD_WIDTH  registered result
result_valid_o  out  1  one-cycle pulse; result_o valid for writeback
busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset (rst_i=1 at a clock edge, in any state): FSM=IDLE, counter=0, result_o=0, result_valid_o=0, busy_o=0. stall_o=0 while rst_i=1.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - start_i=1 and flush_i=0 latches the operands as magnitudes, the result-sign flag and the operator. counter=0.
  - Next state is MUL if operator_i[2]=0, DIV if operator_i[2]=1 and b!=0, DONE if operator_i[2]=1 and b==0 (divide-by-zero early out).
- Magnitudes and result sign:
  - Signed operands are converted to magnitude: a for MUL/MULH/MULHSU/DIV/REM; b for MUL/MULH/DIV/REM.
  - Product sign = sa^sb. Quotient sign = sa^sb. Remainder sign = sa.
- MUL: one shift-add step per cycle into a 2*WORD_WIDTH accumulator, WORD_WIDTH cycles. Transitions to DONE when counter==WORD_WIDTH-1.
- DIV: one restoring shift/subtract step per cycle, WORD_WIDTH cycles. Transitions to DONE when counter==WORD_WIDTH-1.
- DONE:
  - Applies the sign fix (two's-complement negate when the sign flag is set).
  - Registers result_o: MUL takes low word; MULH/MULHSU/MULHU take high word; DIV/DIVU take quotient; REM/REMU take remainder.
  - Pulses result_valid_o.
  - Always returns to IDLE. start_i is ignored in DONE, because the pipeline advances at the end of this cycle.
- stall_o = (IDLE & start_i & !flush_i) | MUL | DIV, with both terms masked by !flush_i. stall_o is 0 in DONE.
- Latency:
  - Acceptance happens in cycle 0.
  - Normal ops: result_valid_o in cycle WORD_WIDTH+1; stall_o high for WORD_WIDTH+1 cycles.
  - Divide-by-zero: result_valid_o in cycle 1; stall_o high for 1 cycle.
- Divide-by-zero results:
  - DIV/DIVU quotient = 0xFFFFFFFF.
  - REM/REMU result = operand_a unchanged.
- Signed overflow: DIV 0x80000000 by 0xFFFFFFFF gives quotient 0x80000000; REM gives 0. This falls out of unsigned magnitude arithmetic with no special case.
- flush_i=1 in any state:
  - Next state is IDLE and the counter is cleared.
  - No result_valid_o pulse is produced, and result_o is unchanged.
  - stall_o drops in the same cycle.
- result_o holds its value until the next DONE.
- Operands are latched at acceptance; changes on operand_*_i during MUL/DIV have no effect.

Decomposition:
- riscv_defines gains:
  - mdu_op_e: 3-bit enum of the eight funct3 codes above.
  - MDU_CNT_WIDTH = $clog2(WORD_WIDTH).
- The state enum stays local to the module.
- Single module, no sub-module. The sign-fix negate is a local function. mdu_seq is instantiated in place of mdu under RISCV_M_CORE.

Test Plan:
- MUL: start with operator 000, a=7, b=-3 (0xFFFFFFFD). Required: stall_o high 33 cycles; result_valid_o at cycle 33; result_o=0xFFFFFFEB.
- MULH/MULHSU/MULHU with a=0x80000000, b=0xFFFFFFFF. Required results 0x00000000, 0x80000000 and 0x7FFFFFFF respectively, each at cycle 33.
- DIV and REM:
  - a=-7, b=2: DIV result 0xFFFFFFFD, REM result 0xFFFFFFFF.
  - a=0x80000000, b=0xFFFFFFFF: DIV result 0x80000000, REM result 0.
- DIVU with b=0 and a=0x1234: result_valid_o at cycle 1, result 0xFFFFFFFF. REMU with the same operands: result 0x1234, stall_o high exactly 1 cycle.
- flush_i pulsed in cycle 10 of a DIV:
  - stall_o drops that cycle, no result_valid_o, busy_o=0 next cycle.
  - result_o keeps its prior value.
  - An immediate new MUL 3*5 returns 15 at cycle 33.
- rst_i asserted in cycle 20 of a MUL:
  - Next cycle busy_o=0, result_o=0, result_valid_o never pulses.
  - start_i held high through the DONE cycle of a later op does not cause a second acceptance.
